// File: rtl/rng_share_ctrl.sv
// Round-robin share of one 3-bit random stream among N_REQ requesters.
// Rejection-samples into 1..limit with a retry cap and fixed fallback.
module rng_share_ctrl #(
  parameter int N_REQ     = 4,
  parameter int MAX_TRIES = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [2:0]           rnd_in,
  input  logic [N_REQ-1:0]     req,
  input  logic [3*N_REQ-1:0]   limit,
  output logic [N_REQ-1:0]     ack,
  output logic [2:0]           value,
  output logic                 fallback,
  output logic                 busy
);

  localparam int IW = (N_REQ > 2) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    DRAW,
    DONE
  } state_t;

  state_t            state, state_d;
  logic [IW-1:0]     idx, idx_d;
  logic [IW-1:0]     ptr, ptr_d;
  logic [2:0]        lim, lim_d;
  logic [3:0]        tries, tries_d;
  logic [N_REQ-1:0]  ack_d;
  logic [2:0]        value_d;
  logic              fb_d;

  logic              found;
  logic [IW-1:0]     gnt;
  logic [IW:0]       sum;
  logic [2:0]        glim;

  // first requester strictly after ptr, wrapping
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    sum   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      sum = {1'b0, ptr} + (IW+1)'(k);
      if (int'(sum) >= N_REQ)
        sum = sum - (IW+1)'(N_REQ);
      if (!found && req[sum[IW-1:0]]) begin
        found = 1'b1;
        gnt   = sum[IW-1:0];
      end
    end
  end

  always_comb begin
    glim = 3'd7;
    for (int i = 0; i < N_REQ; i++)
      if (gnt == IW'(i))
        glim = limit[3*i +: 3];
  end

  always_comb begin
    state_d = state;
    idx_d   = idx;
    ptr_d   = ptr;
    lim_d   = lim;
    tries_d = tries;
    ack_d   = '0;
    value_d = value;
    fb_d    = 1'b0;
    unique case (state)
      IDLE: begin
        if (found) begin
          idx_d   = gnt;
          lim_d   = (glim == 3'd0) ? 3'd7 : glim;
          tries_d = '0;
          state_d = DRAW;
        end
      end
      DRAW: begin
        if (!req[idx]) begin
          ptr_d   = idx;
          state_d = IDLE;
        end else if (rnd_in != 3'd0 && rnd_in <= lim) begin
          value_d    = rnd_in;
          ack_d[idx] = 1'b1;
          state_d    = DONE;
        end else if (tries == 4'(MAX_TRIES-1)) begin
          value_d    = 3'd1;
          fb_d       = 1'b1;
          ack_d[idx] = 1'b1;
          state_d    = DONE;
        end else begin
          tries_d = tries + 4'd1;
        end
      end
      DONE: begin
        ptr_d   = idx;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      ptr      <= IW'(N_REQ-1);
      lim      <= 3'd7;
      tries    <= '0;
      ack      <= '0;
      value    <= '0;
      fallback <= 1'b0;
    end else begin
      state    <= state_d;
      idx      <= idx_d;
      ptr      <= ptr_d;
      lim      <= lim_d;
      tries    <= tries_d;
      ack      <= ack_d;
      value    <= value_d;
      fallback <= fb_d;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_rng_share_ctrl.sv
// Directed bench for rng_share_ctrl.
// Expected values are hand-computed per scenario.
module tb_rng_share_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  rnd_in;
  logic [3:0]  req;
  logic [11:0] limit;
  logic [3:0]  ack;
  logic [2:0]  value;
  logic        fallback;
  logic        busy;

  int nerr = 0;
  int nchk = 0;
  int n;

  rng_share_ctrl #(
    .N_REQ(4),
    .MAX_TRIES(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rnd_in(rnd_in),
    .req(req),
    .limit(limit),
    .ack(ack),
    .value(value),
    .fallback(fallback),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // edges until ack appears, bounded
  task automatic run_to_ack(output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (ack == 4'd0 && cnt < 20);
  endtask

  int rr_a[5] = '{0, 1, 2, 3, 0};
  int rr_b[3] = '{1, 3, 0};

  initial begin
    rst_n  = 1'b0;
    rnd_in = 3'd5;
    req    = 4'b1111;
    limit  = 12'h000;
    tick();
    tick();
    chk("rst_ack", ack, 0);
    chk("rst_value", value, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fb", fallback, 0);
    rst_n = 1'b1;
    run_to_ack(n);
    chk("first_ack", ack, 4'b0001);
    chk("first_lat", n, 2);
    chk("first_value", value, 5);
    req = 4'b0000;
    tick();

    // single request, in range
    req    = 4'b0010;
    limit  = 12'h000;
    limit[5:3] = 3'd6;
    rnd_in = 3'd4;
    tick();
    chk("single_busy", busy, 1);
    chk("single_noack", ack, 0);
    tick();
    chk("single_ack", ack, 4'b0010);
    chk("single_value", value, 4);
    chk("single_fb", fallback, 0);
    req = 4'b0000;
    tick();
    chk("single_ack_off", ack, 0);
    chk("single_idle", busy, 0);
    chk("single_hold", value, 4);

    // fallback after 8 rejections
    req    = 4'b0001;
    limit  = 12'h002;
    rnd_in = 3'd7;
    run_to_ack(n);
    chk("fb_lat", n, 9);
    chk("fb_ack", ack, 4'b0001);
    chk("fb_value", value, 1);
    chk("fb_flag", fallback, 1);
    req = 4'b0000;
    tick();
    chk("fb_flag_off", fallback, 0);

    // rejections 0,5 then accept 2
    req = 4'b0001;
    tick();
    rnd_in = 3'd0;
    tick();
    chk("seq_rej0", ack, 0);
    rnd_in = 3'd5;
    tick();
    chk("seq_rej5", ack, 0);
    rnd_in = 3'd2;
    tick();
    chk("seq_ack", ack, 4'b0001);
    chk("seq_value", value, 2);
    chk("seq_fb", fallback, 0);
    req = 4'b0000;
    tick();

    // round robin from reset
    rst_n = 1'b0;
    tick();
    rst_n  = 1'b1;
    req    = 4'b1111;
    limit  = 12'h000;
    rnd_in = 3'd3;
    for (int i = 0; i < 5; i++) begin
      run_to_ack(n);
      chk("rr_ack", ack, 1 << rr_a[i]);
      chk("rr_period", n, (i == 0) ? 2 : 3);
    end
    req = 4'b1011;
    for (int i = 0; i < 3; i++) begin
      run_to_ack(n);
      chk("rr_drop_ack", ack, 1 << rr_b[i]);
      chk("rr_drop_period", n, 3);
    end
    req = 4'b0000;
    tick();

    // abandon in DRAW, then requester 3
    req    = 4'b1100;
    limit  = 12'h000;
    limit[8:6] = 3'd1;
    rnd_in = 3'd6;
    tick();
    chk("ab_busy", busy, 1);
    tick();
    tick();
    chk("ab_noack", ack, 0);
    req = 4'b1000;
    tick();
    chk("ab_idle", busy, 0);
    chk("ab_ack", ack, 0);
    run_to_ack(n);
    chk("ab_next_ack", ack, 4'b1000);
    chk("ab_next_lat", n, 2);
    chk("ab_next_value", value, 6);
    req = 4'b0000;
    tick();

    // drop coinciding with an in-range sample
    req    = 4'b0001;
    limit  = 12'h000;
    rnd_in = 3'd7;
    tick();
    req    = 4'b0000;
    rnd_in = 3'd3;
    tick();
    chk("sim_ack", ack, 0);
    chk("sim_idle", busy, 0);
    chk("sim_value", value, 6);

    // reset during DRAW
    req    = 4'b0001;
    limit  = 12'h002;
    rnd_in = 3'd7;
    tick();
    tick();
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ack", ack, 0);
    chk("mid_rst_value", value, 0);
    tick();
    rst_n  = 1'b1;
    req    = 4'b1111;
    limit  = 12'h000;
    rnd_in = 3'd3;
    run_to_ack(n);
    chk("mid_after_ack", ack, 4'b0001);
    chk("mid_after_lat", n, 2);
    chk("mid_after_value", value, 3);
    req = 4'b0000;
    tick();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/rng_share_ctrl.md
# rng_share_ctrl

Round-robin controller that shares one free-running 3-bit random source (values 1..7, one new value per clock) among up to N_REQ requesters, such as game logic units. Each requester asks for a value in the range 1..limit. The controller runs a rejection-sampling loop on the stream until a value falls in range, then returns it with a one-cycle acknowledge. A retry cap with a fixed fallback bounds the latency.

## Interface
- N_REQ, default 4: number of requesters (2..8).
- MAX_TRIES, default 8: rejected samples allowed before the fallback (1..15).
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- rnd_in  in  3  random stream; a new value each cycle, nominally 1..7.
- req  in  N_REQ  level request per requester; hold high until ack or abandon.
- limit  in  3*N_REQ  per-requester upper bound, bits [3i+2:3i]; 0 means 7.
- ack  out  N_REQ  one-hot, single-cycle pulse; value is valid in the same cycle.
- value  out  3  delivered random value; held until the next delivery.
- fallback  out  1  high with ack when value came from the retry cap.
- busy  out  1  high while the state is not IDLE.

## Operation
- The FSM has three states: IDLE, DRAW and DONE. All outputs are registered.
- **IDLE**
  - If req is non-zero, grant the first set bit at or after ptr+1, searching round-robin and wrapping at N_REQ.
  - Latch the grant index in idx and the limit in lim, converting 0 to 7.
  - Clear tries and go to DRAW.
- **DRAW**, evaluated each edge:
  - If req[idx] is 0, abandon: go to IDLE, no ack, ptr <= idx.
  - Else if 1 <= rnd_in <= lim: value <= rnd_in, fallback <= 0, ack[idx] <= 1, go to DONE.
  - Else, if tries == MAX_TRIES-1: value <= 1, fallback <= 1, ack[idx] <= 1, go to DONE.
  - Otherwise tries <= tries+1 and stay in DRAW.
  - rnd_in = 0 counts as a rejection.
- **DONE**: ack <= 0, fallback <= 0, ptr <= idx, go to IDLE. value keeps its last delivered value.
- **Priority after reset**: ptr resets to N_REQ-1, so requester 0 has highest priority.
- **Round-robin**: after a grant to requester i, requester i has lowest priority for the next grant. This holds whether the grant was delivered or abandoned.
- **Repeat requests**: a requester still holding req after its ack is a new request. It is arbitrated normally in the next IDLE.
- **Mid-grant changes**:
  - limit changes during DRAW are ignored, since lim is latched at grant.
  - req changes of non-granted requesters during DRAW are ignored.
- **Simultaneous accept and abandon**: if req[idx] falls in the same cycle that an in-range sample arrives, abandon wins and there is no ack.
- **Reset**: asserting reset at any point forces the following immediately, discarding any pending grant:
  - state IDLE, ack 0, value 0, fallback 0, busy 0, tries 0, idx 0, ptr N_REQ-1, lim 7.

## Timing
- Req sampled in IDLE at edge k → DRAW from edge k; first sample of rnd_in at edge k+1.
- Sample accepted at edge k+j (j ≥ 1) → ack and value visible in the cycle after edge k+j. The minimum request-to-ack latency is 2 edges.
- Worst case: ack after edge k+MAX_TRIES, with fallback=1.
- ack is high for exactly one cycle; DONE → IDLE takes one edge. The next grant is at edge k+j+2 at the earliest, so the back-to-back service period is j+2 cycles.
- busy is high from edge k to edge k+j+1, i.e. through DRAW and DONE.
- Each accepted value is one distinct rnd_in sample. No sample is delivered twice.

## Test plan
- Reset value check:
  - Stimulus: reset asserted, rnd_in=5, req=4'b1111.
  - Required: ack=0, value=0, busy=0, fallback=0 while rst_n=0.
  - After release, the first grant goes to requester 0.
- Single request, in range:
  - Stimulus: req=4'b0010, limit1=6, rnd_in=4 at the first DRAW edge.
  - Required: ack=4'b0010 for one cycle, value=4 two edges after the request was sampled, fallback=0.
- Rejection and fallback:
  - Stimulus: limit0=2, MAX_TRIES=8, rnd_in=7 held.
  - Required: exactly 8 DRAW edges, then ack=4'b0001, value=1, fallback=1.
  - Repeat with rnd_in sequence 0,5,2: required value=2 on the third sample, fallback=0.
- Round-robin fairness:
  - Stimulus: req=4'b1111 held, limit=0 for all, rnd_in=3.
  - Required: ack order 0,1,2,3,0 with a 3-cycle period.
  - Drop req2 mid-run: required order becomes 0,1,3,0.
- Abandon during DRAW:
  - Stimulus: req=4'b0100, limit2=1, rnd_in=6; drop req2 after 2 DRAW cycles while req3 is high.
  - Required: no ack to requester 2; return to IDLE; next grant goes to requester 3.
- Reset mid-DRAW:
  - Stimulus: assert rst_n=0 during DRAW.
  - Required: busy=0 and ack=0 immediately.
  - After release, no stale ack, and arbitration restarts at requester 0.
